// File: rtl/tanh_4bit_sweep_checker.sv
// Sweep checker for the 4-bit tanh activation library.
// Drives every input code 0..15 in order into the circuit under test and samples
// its response. Each response is compared with the exact Q0.4 tanh(In/4) table.
// The checker accumulates a mismatch count, an error sum, the worst error with
// the code that first reached it, and a per-code fail map.
module tanh_4bit_sweep_checker #(
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned ERR_TOL = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [3:0]  dut_in,
    input  logic [3:0]  dut_out,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [4:0]  err_cnt,
    output logic [7:0]  err_sum,
    output logic [3:0]  err_max,
    output logic [3:0]  worst_code,
    output logic [15:0] fail_map
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

    // With no settle time the sweep goes straight from one sample to the next.
    localparam state_t     RUN_STATE   = (SETTLE == 0) ? SAMPLE : WAIT;
    localparam logic [3:0] SETTLE_LAST = 4'((SETTLE == 0) ? 0 : SETTLE - 1);
    localparam logic [3:0] TOL         = 4'(ERR_TOL);

    state_t     state;
    state_t     state_next;
    logic [3:0] code;
    logic [3:0] settle_cnt;
    logic [3:0] ref_val;
    logic [3:0] diff;
    logic       accept;
    logic       accumulate;
    logic       advance;
    logic       stop;

    // Exact tanh(In/4) in Q0.4, saturating at 15 from code 7 upwards.
    function automatic logic [3:0] tanh_ref(input logic [3:0] c);
        case (c)
            4'd0:    tanh_ref = 4'd0;
            4'd1:    tanh_ref = 4'd4;
            4'd2:    tanh_ref = 4'd7;
            4'd3:    tanh_ref = 4'd10;
            4'd4:    tanh_ref = 4'd12;
            4'd5:    tanh_ref = 4'd14;
            4'd6:    tanh_ref = 4'd14;
            default: tanh_ref = 4'd15;
        endcase
    endfunction

    // Absolute error of the current response. The larger operand is always
    // subtracted from, so the 4-bit result cannot wrap.
    always_comb begin
        ref_val = tanh_ref(code);
        if (dut_out >= ref_val) begin
            diff = dut_out - ref_val;
        end else begin
            diff = ref_val - dut_out;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the control strobes for the datapath. Abort takes
    // priority over both start and sampling.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        accumulate = 1'b0;
        advance    = 1'b0;
        stop       = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    accept     = 1'b1;
                    state_next = RUN_STATE;
                end
            end
            WAIT: begin
                if (abort) begin
                    stop       = 1'b1;
                    state_next = IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    stop       = 1'b1;
                    state_next = IDLE;
                end else begin
                    accumulate = 1'b1;
                    if (code == 4'd15) begin
                        state_next = DONE;
                    end else begin
                        advance    = 1'b1;
                        state_next = RUN_STATE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Settle counter: runs only while the FSM stays in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= 4'd0;
        end else if (state == WAIT && state_next == WAIT) begin
            settle_cnt <= settle_cnt + 4'd1;
        end else begin
            settle_cnt <= 4'd0;
        end
    end

    // Registered status outputs, derived from the state being entered so they
    // line up with the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == WAIT) || (state_next == SAMPLE);
            done <= (state_next == DONE);
        end
    end

    // Code pointer, validity flag and error accumulators. Results persist
    // after a sweep or an abort until the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code       <= 4'd0;
            valid      <= 1'b0;
            err_cnt    <= 5'd0;
            err_sum    <= 8'd0;
            err_max    <= 4'd0;
            worst_code <= 4'd0;
            fail_map   <= 16'd0;
        end else begin
            if (accept) begin
                code       <= 4'd0;
                valid      <= 1'b0;
                err_cnt    <= 5'd0;
                err_sum    <= 8'd0;
                err_max    <= 4'd0;
                worst_code <= 4'd0;
                fail_map   <= 16'd0;
            end
            if (stop) begin
                code  <= 4'd0;
                valid <= 1'b0;
            end
            if (accumulate) begin
                err_sum <= err_sum + {4'd0, diff};
                if (diff > TOL) begin
                    err_cnt        <= err_cnt + 5'd1;
                    fail_map[code] <= 1'b1;
                end
                if (diff > err_max) begin
                    err_max    <= diff;
                    worst_code <= code;
                end
            end
            if (advance) begin
                code <= code + 4'd1;
            end
            if (state_next == DONE) begin
                valid <= 1'b1;
            end
        end
    end

    assign dut_in = code;

endmodule
